// File: rtl/rgbled_ctrl_pkg.sv
// Shared types for the WS281x frame sequencer: colour record, FSM states and the
// {R,G,B} to {G,R,B} wire-order conversion the LED chain expects.
package rgbled_ctrl_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_IDLE
    } ctrl_state_e;

    function automatic logic [23:0] rgb_to_grb(input rgb_t c);
        return {c.g, c.r, c.b};
    endfunction

endpackage

// File: rtl/rgbled_ctrl.sv
// Frame sequencer for a WS281x chain: per-LED colour store plus an FSM that streams
// one complete frame into the driver's valid/ack/last handshake whenever a change is pending.
module rgbled_ctrl
    import rgbled_ctrl_pkg::*;
#(
    parameter int unsigned NumLeds    = 2,
    parameter int unsigned HoldCycles = 2,
    localparam int unsigned IdxW      = $clog2(NumLeds)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            led_we_i,
    input  logic [IdxW-1:0] led_idx_i,
    input  logic [23:0]     led_rgb_i,
    input  logic            update_i,
    input  logic            off_i,
    output logic            busy_o,
    output logic            frame_done_o,
    output logic            go_o,
    output logic [23:0]     data_o,
    output logic            data_valid_o,
    output logic            data_last_o,
    input  logic            data_ack_i,
    input  logic            idle_i
);

    localparam int unsigned HoldW = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;
    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NumLeds - 1);
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(HoldCycles - 1);

    ctrl_state_e      r_state;
    ctrl_state_e      w_state_d;
    logic [IdxW-1:0]  r_idx;
    logic [IdxW-1:0]  w_idx_d;
    logic [HoldW-1:0] r_hold;
    logic [HoldW-1:0] w_hold_d;
    logic             r_pending;
    rgb_t             r_colour [NumLeds];

    logic w_wr_ok;
    logic w_set;
    logic w_start;

    assign w_wr_ok = led_we_i && (32'(led_idx_i) < NumLeds);
    // Off wins over a simultaneous write, but either one still requests a frame.
    assign w_set   = update_i | off_i | w_wr_ok;
    assign w_start = (r_state == IDLE) & (r_pending | w_set) & idle_i;

    assign busy_o = (r_state != IDLE);
    assign data_o = rgb_to_grb(r_colour[r_idx]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NumLeds); i++) begin
                r_colour[i] <= '0;
            end
        end else if (off_i) begin
            for (int i = 0; i < int'(NumLeds); i++) begin
                r_colour[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_colour[led_idx_i] <= rgb_t'(led_rgb_i);
        end
    end

    // Pending starts set so the chain is blanked after every reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pending <= 1'b1;
        end else if (w_start) begin
            r_pending <= 1'b0;
        end else if (w_set) begin
            r_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_d;
            r_idx   <= w_idx_d;
            r_hold  <= w_hold_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_idx_d      = r_idx;
        w_hold_d     = r_hold;
        go_o         = 1'b0;
        data_valid_o = 1'b0;
        data_last_o  = 1'b0;
        frame_done_o = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_d = SEND;
                    w_idx_d   = '0;
                end
            end
            SEND: begin
                go_o         = 1'b1;
                data_valid_o = 1'b1;
                data_last_o  = (r_idx == LastIdx);
                if (data_ack_i) begin
                    if (r_idx == LastIdx) begin
                        w_state_d = WAIT_IDLE;
                        w_hold_d  = HoldLoad;
                    end else begin
                        w_idx_d = r_idx + 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                if (r_hold != '0) begin
                    w_hold_d = r_hold - 1'b1;
                end else if (idle_i) begin
                    w_state_d    = IDLE;
                    frame_done_o = 1'b1;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rgbled_ctrl.sv
// Directed bench for rgbled_ctrl: reset frame, delayed acks, mid-frame rewrite,
// off priority, out-of-range writes (3-LED instance) and asynchronous reset.
module tb_rgbled_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        led_we = 1'b0;
    logic [0:0]  led_idx = '0;
    logic [23:0] led_rgb = '0;
    logic        update = 1'b0;
    logic        off = 1'b0;
    logic        busy, frame_done, go, data_valid, data_last;
    logic [23:0] data;
    logic        ack = 1'b0;
    logic        idle = 1'b1;

    logic        we3 = 1'b0;
    logic [1:0]  idx3 = '0;
    logic [23:0] rgb3 = '0;
    logic        busy3, done3, go3, valid3, last3;
    logic [23:0] data3;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    rgbled_ctrl #(.NumLeds(2), .HoldCycles(2)) u_dut (
        .clk_i(clk), .rst_i(rst), .led_we_i(led_we), .led_idx_i(led_idx),
        .led_rgb_i(led_rgb), .update_i(update), .off_i(off), .busy_o(busy),
        .frame_done_o(frame_done), .go_o(go), .data_o(data), .data_valid_o(data_valid),
        .data_last_o(data_last), .data_ack_i(ack), .idle_i(idle)
    );

    rgbled_ctrl #(.NumLeds(3), .HoldCycles(2)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .led_we_i(we3), .led_idx_i(idx3),
        .led_rgb_i(rgb3), .update_i(1'b0), .off_i(1'b0), .busy_o(busy3),
        .frame_done_o(done3), .go_o(go3), .data_o(data3), .data_valid_o(valid3),
        .data_last_o(last3), .data_ack_i(1'b1), .idle_i(1'b1)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [0:0] idx, input logic [23:0] rgb);
        led_we  = 1'b1;
        led_idx = idx;
        led_rgb = rgb;
        step();
        led_we  = 1'b0;
    endtask

    task automatic pulse_update();
        update = 1'b1;
        step();
        update = 1'b0;
    endtask

    // Consumes one 2-word frame; acks after dly cycles, optionally rewrites LED1 mid word 0.
    task automatic frame(input logic [23:0] e0, input logic [23:0] e1, input int dly,
                         input bit mid_wr);
        logic [23:0] exp_w [2];
        int n;
        exp_w[0] = e0;
        exp_w[1] = e1;
        for (int w = 0; w < 2; w++) begin
            n = 0;
            while (data_valid !== 1'b1 && n < 20) begin
                step();
                n++;
            end
            chk("valid_seen", data_valid, 1'b1);
            for (int d = 0; d < dly; d++) begin
                chk("data_hold", data, exp_w[w]);
                chk("last_hold", data_last, (w == 1));
                chk("go_hold", go, 1'b1);
                if (mid_wr && w == 0 && d == 0) begin
                    wr(1'b1, 24'h00FF00);
                end else begin
                    step();
                end
            end
            chk("data_ack", data, exp_w[w]);
            chk("last_ack", data_last, (w == 1));
            ack = 1'b1;
            step();
            ack = 1'b0;
        end
        chk("valid_wait", data_valid, 1'b0);
        chk("busy_wait", busy, 1'b1);
        n = 0;
        while (frame_done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("frame_done", frame_done, 1'b1);
        step();
        chk("frame_done_pulse", frame_done, 1'b0);
        chk("busy_after", busy, 1'b0);
    endtask

    initial begin
        int n;
        step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_go", go, 1'b0);
        chk("rst_valid", data_valid, 1'b0);
        chk("rst_last", data_last, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_data", data, 24'h0);

        // All-off frame after reset release, acks every cycle.
        rst = 1'b0;
        step();
        chk("auto_start", data_valid, 1'b1);
        frame(24'h0, 24'h0, 0, 1'b0);
        step();
        chk("no_refire", busy, 1'b0);

        // 3-LED instance: index 3 is out of range and must not start a frame.
        n = 0;
        while (busy3 !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        chk("dut3_idle", busy3, 1'b0);
        we3 = 1'b1; idx3 = 2'd3; rgb3 = 24'h123456;
        step();
        we3 = 1'b0;
        chk("oor_busy0", busy3, 1'b0);
        step();
        chk("oor_busy1", busy3, 1'b0);
        step();
        chk("oor_busy2", busy3, 1'b0);
        we3 = 1'b1; idx3 = 2'd2;
        step();
        we3 = 1'b0;
        chk("inrange_busy", busy3, 1'b1);
        chk("inrange_data0", data3, 24'h0);

        // Writes with the driver busy are deferred; acks outside SEND are ignored.
        idle = 1'b0;
        ack  = 1'b1;
        wr(1'b0, 24'h112233);
        ack  = 1'b0;
        wr(1'b1, 24'hAABBCC);
        chk("defer_busy", busy, 1'b0);
        idle = 1'b1;
        pulse_update();
        chk("latency_valid", data_valid, 1'b1);
        chk("latency_data", data, 24'h221133);
        frame(24'h221133, 24'hBBAACC, 3, 1'b0);

        // Mid-frame colour change resends automatically.
        pulse_update();
        frame(24'h221133, 24'hFF0000, 2, 1'b1);
        frame(24'h221133, 24'hFF0000, 0, 1'b0);
        step();
        chk("one_resend_only", busy, 1'b0);

        // off_i beats a simultaneous write.
        idle = 1'b0;
        off = 1'b1;
        wr(1'b0, 24'hFFFFFF);
        off = 1'b0;
        chk("off_defer", busy, 1'b0);
        idle = 1'b1;
        frame(24'h0, 24'h0, 1, 1'b0);
        pulse_update();
        frame(24'h0, 24'h0, 0, 1'b0);

        // Asynchronous reset in the middle of a frame.
        idle = 1'b0;
        wr(1'b0, 24'h123456);
        idle = 1'b1;
        step();
        chk("pre_rst_valid", data_valid, 1'b1);
        chk("pre_rst_data", data, 24'h341256);
        rst = 1'b1;
        #1;
        chk("arst_go", go, 1'b0);
        chk("arst_valid", data_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_data", data, 24'h0);
        step();
        rst = 1'b0;
        frame(24'h0, 24'h0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
